// File: rtl/fp16_accumulator.sv
// fp16 dot-product accumulator.
// Sums N_TERMS fp16 products through a five-state align/add/norm/round FSM.
module fp16_accumulator #(
  parameter int N_TERMS = 4,
  parameter int CNT_W   = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             busy,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [2:0] {
    S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND
  } state_t;

  state_t state, state_n;

  logic [15:0] acc, op_q;
  logic        accept;

  logic        sgn_q, sub_q, zsign_q, spec_q;
  logic [15:0] spec_v_q;
  logic [4:0]  exp_q;
  logic [13:0] sl_q, ss_q;
  logic [14:0] sum_q;
  logic [13:0] nsig_q;
  logic [4:0]  nexp_q;
  logic        nzero_q, nsign_q;

  assign in_ready = (state == S_IDLE) & ~out_valid & ~clear;
  assign accept   = in_valid & in_ready;
  assign busy     = (state != S_IDLE);

  // State register; reset and clear both abort to IDLE
  always_ff @(posedge CLK) begin
    if (RESET || clear) state <= S_IDLE;
    else                state <= state_n;
  end

  // Next state: every non-idle state lasts one cycle
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (accept) state_n = S_ALIGN;
      S_ALIGN: state_n = S_ADD;
      S_ADD:   state_n = S_NORM;
      S_NORM:  state_n = S_ROUND;
      S_ROUND: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Align: order operands, shift smaller one, detect specials
  logic [15:0] a_op, l_op, s_op, spec_v;
  logic        a_nan, a_inf, b_nan, b_inf, swap, spec;
  logic [4:0]  d;
  logic [10:0] sig_l, sig_s;
  logic [25:0] sh;
  logic [13:0] al;

  always_comb begin
    // An empty accumulator acts as -0, the additive identity
    a_op  = (count == '0) ? 16'h8000 : acc;
    a_nan = (&a_op[14:10]) & (|a_op[9:0]);
    a_inf = (&a_op[14:10]) & ~(|a_op[9:0]);
    b_nan = (&op_q[14:10]) & (|op_q[9:0]);
    b_inf = (&op_q[14:10]) & ~(|op_q[9:0]);
    swap  = op_q[14:0] > a_op[14:0];
    l_op  = swap ? op_q : a_op;
    s_op  = swap ? a_op : op_q;
    sig_l = (|l_op[14:10]) ? {1'b1, l_op[9:0]} : 11'd0;
    sig_s = (|s_op[14:10]) ? {1'b1, s_op[9:0]} : 11'd0;
    d     = l_op[14:10] - s_op[14:10];
    sh    = {sig_s, 15'd0} >> d;
    if (d >= 5'd13) al = {13'd0, |sig_s};
    else            al = {sh[25:13], |sh[12:0]};
    spec   = 1'b1;
    spec_v = 16'h0000;
    if (a_nan)      spec_v = {a_op[15], 15'h7C01};
    else if (b_nan) spec_v = {op_q[15], 15'h7C01};
    else if (a_inf && b_inf && (a_op[15] ^ op_q[15]))
      spec_v = 16'h7C01;
    else if (a_inf) spec_v = a_op;
    else if (b_inf) spec_v = op_q;
    else            spec = 1'b0;
  end

  // Add or subtract aligned significands
  logic [14:0] sum_n;

  always_comb begin
    if (sub_q) sum_n = {1'b0, sl_q} - {1'b0, ss_q};
    else       sum_n = {1'b0, sl_q} + {1'b0, ss_q};
  end

  function automatic logic [3:0] lzc14(input logic [13:0] v);
    lzc14 = 4'd14;
    for (int i = 0; i < 14; i++)
      if (v[i]) lzc14 = 4'(13 - i);
  endfunction

  // Normalize: carry shifts right, otherwise priority-encoded left shift
  logic [3:0]        lz;
  logic [13:0]       nsig;
  logic signed [6:0] ne;
  logic              nzero, nsign;

  always_comb begin
    lz   = lzc14(sum_q[13:0]);
    nsig = sum_q[13:0] << lz;
    ne   = $signed({2'b00, exp_q}) - $signed({3'b000, lz});
    if (sum_q[14]) begin
      nsig = {sum_q[14:2], sum_q[1] | sum_q[0]};
      ne   = $signed({2'b00, exp_q}) + 7'sd1;
    end
    nzero = (sum_q == 15'd0) || (ne < 7'sd1);
    nsign = (sum_q == 15'd0) ? zsign_q : sgn_q;
  end

  // Round to nearest even and pack
  logic        up;
  logic [11:0] rs;
  logic [5:0]  re;
  logic [9:0]  rf;
  logic [15:0] res;

  always_comb begin
    up = nsig_q[2] & (nsig_q[1] | nsig_q[0] | nsig_q[3]);
    rs = {1'b0, nsig_q[13:3]} + {11'd0, up};
    re = {1'b0, nexp_q} + {5'd0, rs[11]};
    rf = rs[11] ? rs[10:1] : rs[9:0];
    if (spec_q)         res = spec_v_q;
    else if (nzero_q)   res = {nsign_q, 15'd0};
    else if (re >= 6'd31)
      res = {nsign_q, 5'h1F, 10'd0};
    else                res = {nsign_q, re[4:0], rf};
  end

  logic [CNT_W-1:0] cnt_n;
  assign cnt_n = count + 1'b1;

  // Datapath registers, counter and output handshake
  always_ff @(posedge CLK) begin
    if (RESET) begin
      acc       <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      op_q      <= '0;
      sgn_q     <= 1'b0;
      sub_q     <= 1'b0;
      zsign_q   <= 1'b0;
      spec_q    <= 1'b0;
      spec_v_q  <= '0;
      exp_q     <= '0;
      sl_q      <= '0;
      ss_q      <= '0;
      sum_q     <= '0;
      nsig_q    <= '0;
      nexp_q    <= '0;
      nzero_q   <= 1'b0;
      nsign_q   <= 1'b0;
    end else if (clear) begin
      acc       <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) op_q <= in_data;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        acc       <= '0;
        count     <= '0;
      end
      if (state == S_ALIGN) begin
        sgn_q    <= l_op[15];
        sub_q    <= l_op[15] ^ s_op[15];
        zsign_q  <= a_op[15] & op_q[15];
        exp_q    <= l_op[14:10];
        sl_q     <= {sig_l, 3'b000};
        ss_q     <= al;
        spec_q   <= spec;
        spec_v_q <= spec_v;
      end
      if (state == S_ADD) sum_q <= sum_n;
      if (state == S_NORM) begin
        nsig_q  <= nsig;
        nexp_q  <= ne[4:0];
        nzero_q <= nzero;
        nsign_q <= nsign;
      end
      if (state == S_ROUND) begin
        acc   <= res;
        count <= cnt_n;
        if (cnt_n == CNT_W'(N_TERMS)) begin
          out_valid <= 1'b1;
          out_data  <= res;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp16_accumulator.sv
// Bench for fp16_accumulator.
// Real-arithmetic reference model, per-cycle compare, directed vectors.
module tb_fp16_accumulator;

  localparam int N  = 4;
  localparam int CW = 8;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [15:0]   in_data = 16'h0;
  logic          in_ready, out_valid, busy;
  logic [15:0]   out_data;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  fp16_accumulator #(.N_TERMS(N), .CNT_W(CW)) dut (
    .CLK(CLK), .RESET(RESET), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .count(count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h",
               nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic real pow2(input int e);
    real r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real f2r(input logic [15:0] h);
    real v;
    if (h[14:10] == 5'd0) return 0.0;
    v = (1024.0 + real'(h[9:0])) * pow2(int'(h[14:10]) - 25);
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] r2f(input real x,
                                      input logic zs);
    logic s;
    real m, sg, fl;
    int e, fi;
    if (x == 0.0) return {zs, 15'd0};
    s = (x < 0.0);
    m = s ? -x : x;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    if (e < -14) return {s, 15'd0};
    sg = m * 1024.0;
    fl = $floor(sg);
    fi = int'(fl);
    if ((sg - fl) > 0.5 || ((sg - fl) == 0.5 && fi % 2 == 1))
      fi++;
    if (fi == 2048) begin fi = 1024; e++; end
    if (e + 15 >= 31) return {s, 15'h7C00};
    return {s, 5'(e + 15), 10'(fi - 1024)};
  endfunction

  function automatic logic isnan(input logic [15:0] h);
    return (h[14:10] == 5'h1F) && (h[9:0] != 0);
  endfunction

  function automatic logic isinf(input logic [15:0] h);
    return (h[14:10] == 5'h1F) && (h[9:0] == 0);
  endfunction

  function automatic logic [15:0] fadd(input logic [15:0] a,
                                       input logic [15:0] b);
    if (isnan(a)) return {a[15], 15'h7C01};
    if (isnan(b)) return {b[15], 15'h7C01};
    if (isinf(a) && isinf(b) && a[15] != b[15])
      return 16'h7C01;
    if (isinf(a)) return a;
    if (isinf(b)) return b;
    return r2f(f2r(a) + f2r(b), a[15] & b[15]);
  endfunction

  function automatic logic [15:0] first(input logic [15:0] b);
    if (isnan(b)) return {b[15], 15'h7C01};
    if (b[14:10] == 5'd0) return {b[15], 15'd0};
    return b;
  endfunction

  logic [15:0] m_acc = 0, m_op = 0, m_od = 0;
  int          m_busy = 0, m_cnt = 0, m_b0;
  logic        m_ov = 0, m_ov0;

  always @(posedge CLK) begin
    m_b0  = m_busy;
    m_ov0 = m_ov;
    if (RESET) begin
      m_busy = 0; m_cnt = 0; m_acc = 0;
      m_ov = 0; m_od = 0;
    end else if (clear) begin
      m_busy = 0; m_cnt = 0; m_acc = 0; m_ov = 0;
    end else begin
      if (m_ov0 && out_ready) begin
        m_ov = 0; m_acc = 0; m_cnt = 0;
      end
      if (m_b0 == 0) begin
        if (!m_ov0 && in_valid) begin
          m_op = in_data;
          m_busy = 4;
        end
      end else begin
        m_busy = m_b0 - 1;
        if (m_busy == 0) begin
          m_acc = (m_cnt == 0) ? first(m_op)
                               : fadd(m_acc, m_op);
          m_cnt++;
          if (m_cnt == N) begin
            m_ov = 1;
            m_od = m_acc;
          end
        end
      end
    end
  end

  always @(negedge CLK) begin
    chk("cyc_busy", 32'(busy), 32'(m_busy != 0));
    chk("cyc_count", 32'(count), 32'(m_cnt));
    chk("cyc_out_valid", 32'(out_valid), 32'(m_ov));
    chk("cyc_out_data", 32'(out_data), 32'(m_od));
    chk("cyc_in_ready", 32'(in_ready),
        32'((m_busy == 0) && !m_ov && !clear));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic send(input logic [15:0] d,
                      input logic chk_busy);
    int n = 0;
    int b = 0;
    logic ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    while (n < 100) begin
      #1;
      ok = in_ready;
      @(posedge CLK);
      #2;
      if (ok) break;
      n++;
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout data=%h", d);
    end
    if (chk_busy) begin
      while (busy && b < 20) begin b++; tick(); end
      chk("busy_len", 32'(b), 32'd4);
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL out_valid_timeout count=%0d", count);
    end
  endtask

  task automatic hs();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run_vec(input string nm,
                         input logic [63:0] v,
                         input logic [15:0] exp,
                         input logic cb);
    for (int i = 0; i < 4; i++)
      send(v[63-16*i -: 16], cb);
    wait_valid();
    chk(nm, 32'(out_data), 32'(exp));
    hs();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    RESET = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h0);

    chk("mdl_3c00_1400", 32'(fadd(16'h3C00, 16'h1400)), 32'h3C01);
    chk("mdl_3c01_1000", 32'(fadd(16'h3C01, 16'h1000)), 32'h3C02);
    chk("mdl_4600_4400", 32'(fadd(16'h4600, 16'h4400)), 32'h4900);
    chk("mdl_7bff_7bff", 32'(fadd(16'h7BFF, 16'h7BFF)), 32'h7C00);
    chk("mdl_3c00_bc00", 32'(fadd(16'h3C00, 16'hBC00)), 32'h0000);
    chk("mdl_8000_8000", 32'(fadd(16'h8000, 16'h8000)), 32'h8000);
    chk("mdl_inf_ninf", 32'(fadd(16'h7C00, 16'hFC00)), 32'h7C01);

    run_vec("vec_basic", 64'h3C00_4000_4200_4400, 16'h4900, 1'b1);
    run_vec("vec_tie", 64'h3C00_1400_1000_0000, 16'h3C02, 1'b0);
    run_vec("vec_cancel", 64'h3C00_BC00_0000_8000, 16'h0000, 1'b0);
    run_vec("vec_negzero", 64'h8000_8000_8000_8000, 16'h8000, 1'b0);
    run_vec("vec_ovf", 64'h7BFF_7BFF_3C00_3C00, 16'h7C00, 1'b0);
    run_vec("vec_infnan", 64'h7C00_FC00_3C00_3C00, 16'h7C01, 1'b0);

    for (int i = 0; i < 4; i++)
      send((i == 1) ? 16'h7C01 : 16'h3C00, 1'b0);
    wait_valid();
    chk("nan_exp", 32'(out_data[14:10]), 32'h1F);
    chk("nan_frac_nz", 32'(out_data[9:0] != 0), 32'd1);
    hs();

    for (int i = 0; i < 4; i++) send(16'h3C00, 1'b0);
    wait_valid();
    in_valid = 1'b1;
    in_data  = 16'h4000;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), 32'h4400);
      chk("bp_ready", 32'(in_ready), 32'd0);
      @(posedge CLK);
      #2;
    end
    in_valid = 1'b0;
    hs();
    chk("hs_valid", 32'(out_valid), 32'd0);
    chk("hs_count", 32'(count), 32'd0);
    run_vec("vec_after_bp", 64'h4000_4000_4000_4000, 16'h4800, 1'b0);

    send(16'h3C00, 1'b0);
    send(16'h4000, 1'b0);
    tick();
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_count", 32'(count), 32'd0);
    chk("rstmid_valid", 32'(out_valid), 32'd0);
    chk("rstmid_data", 32'(out_data), 32'h0);

    run_vec("vec_pre_clr", 64'h3C00_3C00_3C00_3C00, 16'h4400, 1'b0);
    send(16'h3C00, 1'b0);
    send(16'h4000, 1'b0);
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clrmid_busy", 32'(busy), 32'd0);
    chk("clrmid_count", 32'(count), 32'd0);
    chk("clrmid_valid", 32'(out_valid), 32'd0);
    chk("clrmid_data", 32'(out_data), 32'h4400);

    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h3C00;
    #1;
    chk("clr_in_ready", 32'(in_ready), 32'd0);
    @(posedge CLK);
    #2;
    tick();
    chk("clr_in_count", 32'(count), 32'd0);
    chk("clr_in_busy", 32'(busy), 32'd0);
    clear    = 1'b0;
    in_valid = 1'b0;

    run_vec("vec_final", 64'h3C00_4000_4200_4400, 16'h4900, 1'b0);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
